// File: rtl/ll_drain_if.sv
// Handshake bundle between the link-list drain engine and its neighbours.
// master = drain engine; slave = queues, link-list manager and completion sink.
interface ll_drain_if #(
  parameter int unsigned lpsz      = 8,
  parameter int unsigned channels  = 2,
  parameter int unsigned max_pages = 64
);
  localparam int unsigned lpdsz = lpsz + 1;
  localparam int unsigned chw   = (channels > 1) ? $clog2(channels) : 1;
  localparam int unsigned cntw  = $clog2(max_pages + 1);

  logic [channels-1:0]      op_srdy;
  logic [channels-1:0]      op_drdy;
  logic [channels*lpsz-1:0] op_page;
  logic                     rlp_srdy;
  logic                     rlp_drdy;
  logic [lpsz-1:0]          rlp_rd_page;
  logic                     rlpr_srdy;
  logic                     rlpr_drdy;
  logic [lpdsz-1:0]         rlpr_data;
  logic                     drf_srdy;
  logic                     drf_drdy;
  logic [2*lpsz-1:0]        drf_page_list;
  logic                     done_srdy;
  logic                     done_drdy;
  logic [chw-1:0]           done_chan;
  logic [cntw-1:0]          done_pgcount;
  logic                     done_err;

  modport master (
    input  op_srdy, op_page, rlp_drdy, rlpr_srdy, rlpr_data, drf_drdy, done_drdy,
    output op_drdy, rlp_srdy, rlp_rd_page, rlpr_drdy, drf_srdy, drf_page_list,
           done_srdy, done_chan, done_pgcount, done_err
  );

  modport slave (
    output op_srdy, op_page, rlp_drdy, rlpr_srdy, rlpr_data, drf_drdy, done_drdy,
    input  op_drdy, rlp_srdy, rlp_rd_page, rlpr_drdy, drf_srdy, drf_page_list,
           done_srdy, done_chan, done_pgcount, done_err
  );
endinterface

// File: rtl/ll_drain_engine.sv
// Multi-channel packet drain: round-robin accept, walk the page chain via link
// reads, return freed pages to the free list and report per-packet completion.
module ll_drain_engine #(
  parameter int unsigned lpsz         = 8,
  parameter int unsigned lpdsz        = lpsz + 1,
  parameter int unsigned channels     = 2,
  parameter int unsigned max_pages    = 64,
  parameter bit          batch_return = 1'b1
) (
  input logic        clk,
  input logic        reset,
  ll_drain_if.master bus
);
  localparam int unsigned chw  = (channels > 1) ? $clog2(channels) : 1;
  localparam int unsigned cntw = $clog2(max_pages + 1);

  typedef enum logic [2:0] {StIdle, StReq, StResp, StRet, StDone} state_e;

  state_e            state_q, state_d;
  logic [chw-1:0]    rr_ptr_q, rr_ptr_d;
  logic [chw-1:0]    chan_q, chan_d;
  logic [lpsz-1:0]   start_q, start_d;
  logic [lpsz-1:0]   cur_q, cur_d;
  logic [lpsz-1:0]   nxt_q, nxt_d;
  logic [cntw-1:0]   pgcount_q, pgcount_d;
  logic              err_q, err_d;
  logic              last_q, last_d;

  logic              rlp_srdy_q, rlp_srdy_d;
  logic [lpsz-1:0]   rlp_rd_page_q, rlp_rd_page_d;
  logic              drf_srdy_q, drf_srdy_d;
  logic [2*lpsz-1:0] drf_list_q, drf_list_d;
  logic              done_srdy_q, done_srdy_d;
  logic [chw-1:0]    done_chan_q, done_chan_d;
  logic [cntw-1:0]   done_pgcount_q, done_pgcount_d;
  logic              done_err_q, done_err_d;

  logic [lpsz-1:0]   page_arr [channels];
  logic              grant_vld;
  logic [chw-1:0]    grant;
  logic [cntw-1:0]   pg_inc;
  logic              link_end;
  logic              hit_max;

  for (genvar c = 0; c < channels; c++) begin : g_page
    assign page_arr[c] = bus.op_page[c*lpsz +: lpsz];
  end

  // First requesting channel at or after rr_ptr, with wrap-around.
  always_comb begin
    int unsigned idx;
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    for (int unsigned i = 0; i < channels; i++) begin
      idx = (32'(rr_ptr_q) + i) % channels;
      if (!grant_vld && bus.op_srdy[chw'(idx)]) begin
        grant_vld = 1'b1;
        grant     = chw'(idx);
      end
    end
  end

  always_comb begin
    bus.op_drdy = '0;
    if (state_q == StIdle && grant_vld && !reset) bus.op_drdy[grant] = 1'b1;
  end

  assign bus.rlpr_drdy = (state_q == StResp);

  assign pg_inc   = pgcount_q + 1'b1;
  assign link_end = bus.rlpr_data[lpdsz-1];
  assign hit_max  = (pg_inc == cntw'(max_pages));

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    chan_d         = chan_q;
    start_d        = start_q;
    cur_d          = cur_q;
    nxt_d          = nxt_q;
    pgcount_d      = pgcount_q;
    err_d          = err_q;
    last_d         = last_q;
    rlp_srdy_d     = rlp_srdy_q;
    rlp_rd_page_d  = rlp_rd_page_q;
    drf_srdy_d     = drf_srdy_q;
    drf_list_d     = drf_list_q;
    done_srdy_d    = done_srdy_q;
    done_chan_d    = done_chan_q;
    done_pgcount_d = done_pgcount_q;
    done_err_d     = done_err_q;

    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          start_d       = page_arr[grant];
          cur_d         = page_arr[grant];
          chan_d        = grant;
          pgcount_d     = '0;
          err_d         = 1'b0;
          last_d        = 1'b0;
          rr_ptr_d      = (32'(grant) == channels - 1) ? '0 : grant + 1'b1;
          rlp_srdy_d    = 1'b1;
          rlp_rd_page_d = page_arr[grant];
          state_d       = StReq;
        end
      end
      StReq: begin
        if (bus.rlp_drdy) begin
          rlp_srdy_d = 1'b0;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (bus.rlpr_srdy) begin
          nxt_d     = bus.rlpr_data[lpsz-1:0];
          pgcount_d = pg_inc;
          last_d    = link_end | hit_max;
          err_d     = ~link_end & hit_max;
          if (!batch_return) begin
            drf_srdy_d = 1'b1;
            drf_list_d = {cur_q, cur_q};
            state_d    = StRet;
          end else if (link_end | hit_max) begin
            drf_srdy_d = 1'b1;
            drf_list_d = {start_q, cur_q};
            state_d    = StRet;
          end else begin
            cur_d         = bus.rlpr_data[lpsz-1:0];
            rlp_srdy_d    = 1'b1;
            rlp_rd_page_d = bus.rlpr_data[lpsz-1:0];
            state_d       = StReq;
          end
        end
      end
      StRet: begin
        if (bus.drf_drdy) begin
          drf_srdy_d = 1'b0;
          if (last_q) begin
            done_srdy_d    = 1'b1;
            done_chan_d    = chan_q;
            done_pgcount_d = pgcount_q;
            done_err_d     = err_q;
            state_d        = StDone;
          end else begin
            cur_d         = nxt_q;
            rlp_srdy_d    = 1'b1;
            rlp_rd_page_d = nxt_q;
            state_d       = StReq;
          end
        end
      end
      StDone: begin
        if (bus.done_drdy) begin
          done_srdy_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Synchronous reset drops any packet in flight without emitting anything for it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      rr_ptr_q       <= '0;
      chan_q         <= '0;
      start_q        <= '0;
      cur_q          <= '0;
      nxt_q          <= '0;
      pgcount_q      <= '0;
      err_q          <= 1'b0;
      last_q         <= 1'b0;
      rlp_srdy_q     <= 1'b0;
      rlp_rd_page_q  <= '0;
      drf_srdy_q     <= 1'b0;
      drf_list_q     <= '0;
      done_srdy_q    <= 1'b0;
      done_chan_q    <= '0;
      done_pgcount_q <= '0;
      done_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      chan_q         <= chan_d;
      start_q        <= start_d;
      cur_q          <= cur_d;
      nxt_q          <= nxt_d;
      pgcount_q      <= pgcount_d;
      err_q          <= err_d;
      last_q         <= last_d;
      rlp_srdy_q     <= rlp_srdy_d;
      rlp_rd_page_q  <= rlp_rd_page_d;
      drf_srdy_q     <= drf_srdy_d;
      drf_list_q     <= drf_list_d;
      done_srdy_q    <= done_srdy_d;
      done_chan_q    <= done_chan_d;
      done_pgcount_q <= done_pgcount_d;
      done_err_q     <= done_err_d;
    end
  end

  assign bus.rlp_srdy      = rlp_srdy_q;
  assign bus.rlp_rd_page   = rlp_rd_page_q;
  assign bus.drf_srdy      = drf_srdy_q;
  assign bus.drf_page_list = drf_list_q;
  assign bus.done_srdy     = done_srdy_q;
  assign bus.done_chan     = done_chan_q;
  assign bus.done_pgcount  = done_pgcount_q;
  assign bus.done_err      = done_err_q;
endmodule

// File: tb/tb_ll_drain_engine.sv
// Bench for ll_drain_engine: three instances (batch, per-page, max_pages=4) driven by
// queue-based producers and a link memory, checked against a packet-walk reference model.
module tb_ll_drain_engine;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [NI];
  logic [8:0]  link_mem [256];
  logic [7:0]  opq [NI*2][$];
  logic [7:0]  mq [NI*2][$];
  int unsigned log_q [NI][$];
  int unsigned exp_q [$];
  int          nreads [NI];
  int          ndone [NI];
  bit          stall_en [NI];
  bit          freeze [NI];
  logic [31:0] outs_vec [NI];
  logic [15:0] list_vec [NI];
  logic        rlpr_drdy_vec [NI];
  int          checks = 0;
  int          errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : env
    localparam int unsigned MP = (g == 2) ? 4 : 64;
    localparam bit          BR = (g != 1);

    ll_drain_if #(.lpsz(8), .channels(2), .max_pages(MP)) bus ();

    ll_drain_engine #(
      .lpsz(8), .lpdsz(9), .channels(2), .max_pages(MP), .batch_return(BR)
    ) dut (
      .clk(clk),
      .reset(rst[g]),
      .bus(bus)
    );

    assign outs_vec[g] = 32'({bus.op_drdy, bus.rlp_srdy, bus.rlp_rd_page, bus.rlpr_drdy,
                              bus.drf_srdy, bus.done_srdy, bus.done_chan, bus.done_pgcount,
                              bus.done_err});
    assign list_vec[g] = bus.drf_page_list;
    assign rlpr_drdy_vec[g] = bus.rlpr_drdy;

    initial begin : drive
      bit          pend, h_rlp, h_drf, h_done;
      logic [7:0]  pend_pg, h_pg;
      logic [15:0] h_list;
      logic [31:0] h_dn, dn;
      pend = 0; h_rlp = 0; h_drf = 0; h_done = 0;
      pend_pg = '0; h_pg = '0; h_list = '0; h_dn = '0; dn = '0;
      bus.op_srdy = '0; bus.op_page = '0; bus.rlp_drdy = 1'b0; bus.rlpr_srdy = 1'b0;
      bus.rlpr_data = '0; bus.drf_drdy = 1'b0; bus.done_drdy = 1'b0;
      forever begin
        @(negedge clk);
        if (rst[g]) begin
          pend = 0; h_rlp = 0; h_drf = 0; h_done = 0;
          bus.op_srdy = '0;
          bus.rlpr_srdy = 1'b0;
        end else begin
          for (int c = 0; c < 2; c++) begin
            bus.op_srdy[c] = (opq[g*2+c].size() > 0);
            if (opq[g*2+c].size() > 0) bus.op_page[c*8 +: 8] = opq[g*2+c][0];
          end
          bus.rlp_drdy  = !stall_en[g] || ($urandom_range(0, 1) == 1);
          bus.drf_drdy  = !stall_en[g] || ($urandom_range(0, 1) == 1);
          bus.done_drdy = !stall_en[g] || ($urandom_range(0, 1) == 1);
          if (!pend) bus.rlpr_srdy = 1'b0;
          else if (!bus.rlpr_srdy && !(freeze[g] && nreads[g] == 2) &&
                   (!stall_en[g] || $urandom_range(0, 1) == 1)) begin
            bus.rlpr_srdy = 1'b1;
            bus.rlpr_data = link_mem[pend_pg];
          end
          #1;
          dn = 32'h0300_0000 | (32'(bus.done_chan) << 16) | (32'(bus.done_err) << 8) |
               32'(bus.done_pgcount);
          if (h_rlp)
            check_eq("rlp_hold", 32'({bus.rlp_srdy, bus.rlp_rd_page}), 32'({1'b1, h_pg}));
          if (h_drf)
            check_eq("drf_hold", 32'({bus.drf_srdy, bus.drf_page_list}), 32'({1'b1, h_list}));
          if (h_done)
            check_eq("done_hold", dn | (32'(bus.done_srdy) << 28), h_dn | 32'h1000_0000);
          for (int c = 0; c < 2; c++)
            if (bus.op_srdy[c] && bus.op_drdy[c]) void'(opq[g*2+c].pop_front());
          if (bus.rlpr_srdy && bus.rlpr_drdy) pend = 0;
          if (bus.rlp_srdy && bus.rlp_drdy) begin
            log_q[g].push_back(32'h0100_0000 | 32'(bus.rlp_rd_page));
            nreads[g]++;
            pend    = 1;
            pend_pg = bus.rlp_rd_page;
          end
          if (bus.drf_srdy && bus.drf_drdy)
            log_q[g].push_back(32'h0200_0000 | 32'(bus.drf_page_list));
          if (bus.done_srdy && bus.done_drdy) begin
            log_q[g].push_back(dn);
            ndone[g]++;
          end
          h_rlp  = bus.rlp_srdy && !bus.rlp_drdy;
          h_pg   = bus.rlp_rd_page;
          h_drf  = bus.drf_srdy && !bus.drf_drdy;
          h_list = bus.drf_page_list;
          h_done = bus.done_srdy && !bus.done_drdy;
          h_dn   = dn;
        end
      end
    end
  end

  task automatic clear(input int i);
    log_q[i].delete();
    nreads[i] = 0;
    ndone[i]  = 0;
    mq[i*2].delete();
    mq[i*2+1].delete();
  endtask

  task automatic load(input int i, input int c, input logic [7:0] pg);
    opq[i*2+c].push_back(pg);
    mq[i*2+c].push_back(pg);
  endtask

  task automatic do_reset(input int i);
    @(negedge clk); #2;
    rst[i] = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    rst[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int n, input string tag);
    int cyc;
    cyc = 0;
    while (ndone[i] < n && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_ndone"}, 32'(ndone[i]), 32'(n));
    repeat (3) @(negedge clk);
  endtask

  // Reference: serve channels round-robin from pointer 0 and walk each chain in link_mem.
  task automatic compare(input int i, input int mp, input bit br, input string tag);
    int         ptr, ch, n;
    bit         err, fin;
    logic [7:0] st, cur;
    logic [8:0] lnk;
    ptr = 0;
    exp_q.delete();
    forever begin
      ch = -1;
      for (int k = 0; k < 2; k++)
        if (ch < 0 && mq[i*2 + (ptr + k) % 2].size() > 0) ch = (ptr + k) % 2;
      if (ch < 0) break;
      st  = mq[i*2+ch].pop_front();
      ptr = (ch + 1) % 2;
      cur = st; n = 0; err = 0; fin = 0;
      while (!fin) begin
        n++;
        exp_q.push_back(32'h0100_0000 | 32'(cur));
        lnk = link_mem[cur];
        fin = lnk[8] || n == mp;
        err = !lnk[8] && n == mp;
        if (!br) exp_q.push_back(32'h0200_0000 | 32'({cur, cur}));
        if (fin && br) exp_q.push_back(32'h0200_0000 | 32'({st, cur}));
        if (!fin) cur = lnk[7:0];
      end
      exp_q.push_back(32'h0300_0000 | (32'(ch) << 16) | (32'(err) << 8) | 32'(n));
    end
    check_eq({tag, "_nev"}, 32'(log_q[i].size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < log_q[i].size(); k++)
      check_eq($sformatf("%s_ev%0d", tag, k), log_q[i][k], exp_q[k]);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; stall_en[i] = 0; freeze[i] = 0; nreads[i] = 0; ndone[i] = 0;
    end
    for (int p = 0; p < 256; p++) link_mem[p] = 9'h100;
    repeat (3) @(negedge clk);
    #2;
    for (int i = 0; i < NI; i++) begin
      check_eq("reset_outs", outs_vec[i], 32'h0);
      check_eq("reset_list", 32'(list_vec[i]), 32'h0);
      rst[i] = 1'b0;
    end
    @(negedge clk); #2;
    check_eq("idle_outs", outs_vec[0], 32'h0);

    // Batch return, chain 5 -> 9 -> 2 -> stop
    link_mem[5] = 9'h009; link_mem[9] = 9'h002; link_mem[2] = 9'h100;
    clear(0); load(0, 0, 8'd5);
    wait_done(0, 1, "batch");
    compare(0, 64, 1'b1, "batch");

    // Per-page return, same chain
    clear(1); load(1, 0, 8'd5);
    wait_done(1, 1, "perpage");
    compare(1, 64, 1'b0, "perpage");

    // Both channels contending with one-page packets
    do_reset(0);
    link_mem[1] = 9'h100; link_mem[7] = 9'h1FF;
    clear(0);
    for (int k = 0; k < 4; k++) begin
      load(0, 0, 8'd1);
      load(0, 1, 8'd7);
    end
    wait_done(0, 8, "rr");
    compare(0, 64, 1'b1, "rr");

    // Loop guard on circular chain 3 -> 4 -> 3
    link_mem[3] = 9'h004; link_mem[4] = 9'h003;
    clear(2); load(2, 0, 8'd3);
    wait_done(2, 1, "guard");
    compare(2, 4, 1'b1, "guard");

    // Random chains and packets with random backpressure on every handshake
    for (int i = 0; i < NI; i++) do_reset(i);
    for (int p = 0; p < 256; p++)
      link_mem[p] = {($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255))};
    for (int i = 0; i < NI; i++) begin
      clear(i);
      stall_en[i] = 1;
      for (int k = 0; k < 12; k++) load(i, $urandom_range(0, 1), 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < NI; i++) wait_done(i, 12, "rand");
    compare(0, 64, 1'b1, "rand0");
    compare(1, 64, 1'b0, "rand1");
    compare(2, 4, 1'b1, "rand2");
    for (int i = 0; i < NI; i++) stall_en[i] = 0;

    // Reset while waiting for the second link response of a 3-page packet
    link_mem[5] = 9'h009; link_mem[9] = 9'h002; link_mem[2] = 9'h100;
    do_reset(0);
    clear(0);
    freeze[0] = 1;
    load(0, 0, 8'd5);
    cyc = 0;
    do begin
      @(negedge clk); #2;
      cyc++;
    end while (!(nreads[0] == 2 && rlpr_drdy_vec[0]) && cyc < 200);
    check_eq("abort_reach", 32'(nreads[0] == 2 && rlpr_drdy_vec[0]), 32'h1);
    rst[0] = 1'b1;
    @(negedge clk); #2;
    check_eq("abort_outs", outs_vec[0], 32'h0);
    check_eq("abort_list", 32'(list_vec[0]), 32'h0);
    rst[0] = 1'b0;
    freeze[0] = 0;
    repeat (10) @(negedge clk);
    check_eq("abort_nev", 32'(log_q[0].size()), 32'd2);
    check_eq("abort_rd0", log_q[0][0], 32'h0100_0005);
    check_eq("abort_ndone", 32'(ndone[0]), 32'd0);
    clear(0);
    load(0, 0, 8'd5);
    wait_done(0, 1, "after");
    compare(0, 64, 1'b1, "after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ll_drain_engine.md
# ll_drain_engine

Synthesizable, multi-channel successor to the write-port stub that drains packets out of the link-list manager. Each channel presents packet start pages. The engine arbitrates round-robin between channels and walks each packet's page chain through the read-link-page interface. It returns the freed pages to the free list, either as one `{start,end}` span or page by page, and reports per-packet completion status. It sits between the output-port queues and the link-list manager.

## Interface
- `lpsz`, 8: page number width.
- `lpdsz`, `lpsz+1`: link data width; MSB is the end-of-list flag.
- `channels`, 2: number of input channels (≥1).
- `max_pages`, 64: loop guard; the maximum pages walked per packet (≥1).
- `batch_return`, 1: 1 = one `{start,end}` return per packet; 0 = one `{pg,pg}` return per page.
- Derived: `chw = (channels>1) ? $clog2(channels) : 1`; `cntw = $clog2(max_pages+1)`.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `op_srdy`, in, `channels`: per-channel start page valid.
- `op_drdy`, out, `channels`: per-channel accept.
- `op_page`, in, `channels*lpsz`: start pages; channel c occupies bits `[c*lpsz +: lpsz]`.
- `rlp_srdy`, out, 1: link read request valid.
- `rlp_drdy`, in, 1: link read request accept.
- `rlp_rd_page`, out, `lpsz`: page whose link is read.
- `rlpr_srdy`, in, 1: link read response valid.
- `rlpr_drdy`, out, 1: link read response accept.
- `rlpr_data`, in, `lpdsz`: next-page link.
- `drf_srdy`, out, 1: free-list return valid.
- `drf_drdy`, in, 1: free-list return accept.
- `drf_page_list`, out, `2*lpsz`: `{start,end}`.
- `done_srdy`, out, 1: packet completion valid.
- `done_drdy`, in, 1: completion accept.
- `done_chan`, out, `chw`: channel of the completed packet.
- `done_pgcount`, out, `cntw`: pages walked.
- `done_err`, out, 1: loop guard tripped.

## Operation
FSM states: IDLE, REQ, RESP, RET, DONE.
- **IDLE:** The grant goes to the first channel with `op_srdy` set, searching from `rr_ptr` upward with wrap-around.
  - `op_drdy[grant]=1` (combinational, IDLE only).
  - On transfer: `start=cur=op_page[grant]`, `chan=grant`, `pgcount=0`, `err=0`, `rr_ptr=grant+1` (mod `channels`), go to REQ.
  - With no `op_srdy`, the FSM stays in IDLE.
- **REQ:** `rlp_srdy=1`, `rlp_rd_page=cur`, held stable until `rlp_drdy`, then go to RESP.
- **RESP:** `rlpr_drdy=1`. On `rlpr_srdy`:
  - Capture `nxt=rlpr_data`.
  - Set `pgcount=pgcount+1`, `end=cur`.
  - Set `last = nxt[lpdsz-1] | (pgcount+1 == max_pages)`.
  - Set `err = ~nxt[lpdsz-1] & (pgcount+1 == max_pages)`.
- **Next state from RESP:**
  - `batch_return=0`: go to RET with `drf_page_list={cur,cur}`.
  - `batch_return=1` and `last`: go to RET with `{start,end}`.
  - Otherwise: `cur=nxt[lpsz-1:0]`, go to REQ.
- **RET:** `drf_srdy=1` until `drf_drdy`. Then:
  - If `last`, go to DONE.
  - Otherwise `cur=nxt[lpsz-1:0]`, go to REQ.
- **DONE:** `done_srdy=1` with `chan`, `pgcount`, `err` until `done_drdy`, then go to IDLE.
- Only one packet is in flight at a time; no new `op_drdy` is issued until DONE completes.
- Any link with MSB set terminates the chain; its low bits are ignored.
- The loop guard fires when the `max_pages`-th read returns a non-terminal link. The packet is then closed with the pages walked so far and `done_err=1`.

## Timing
- All outputs except `op_drdy` and `rlpr_drdy` are registered; those two are decoded from the registered state.
- Reset values:
  - `op_drdy=0`, `rlp_srdy=0`, `rlp_rd_page=0`, `rlpr_drdy=0`, `drf_srdy=0`, `drf_page_list=0`.
  - `done_srdy=0`, `done_chan=0`, `done_pgcount=0`, `done_err=0`.
  - State IDLE, `rr_ptr=0`.
- Latency with zero backpressure:
  - Accept to first `rlp_srdy`: 1 cycle.
  - Each page costs REQ (1) + RESP (1) cycles, plus 1 RET cycle when `batch_return=0`.
- A single packet spends minimum 1 cycle in RET and 1 in DONE.
- `srdy` is never dropped and its data never changes before the matching `drdy`.
- Reset mid-walk aborts immediately and discards partial state. No return or completion is emitted for the aborted packet.

## Test plan
- Batch mode, ch0 start=5, chain 5→9→2→stop(`0x100`):
  - Three reads of 5, 9, 2.
  - One return `{5,2}`.
  - Done `chan=0`, `pgcount=3`, `err=0`.
- `batch_return=0`, same chain:
  - Returns `{5,5}`, `{9,9}`, `{2,2}` in order, each after its read.
  - Done `pgcount=3`.
- Both channels assert together (ch0=1 and ch1=7, one-page packets), repeated 4 times:
  - Grants alternate 0,1,0,1.
  - `done_chan` sequence matches.
- `max_pages=4`, circular chain 3→4→3:
  - Exactly 4 reads.
  - Return `{3,4}`.
  - Done `pgcount=4`, `err=1`.
- Random stalls on `rlp_drdy`, `rlpr_srdy`, `drf_drdy` and `done_drdy` (0-5 cycles):
  - Results identical to the unstalled runs.
  - `srdy` and data held stable throughout each stall.
- Reset asserted while in RESP on page 2 of 3:
  - All outputs return to 0 the next cycle.
  - No `drf` or `done` is emitted.
  - A new packet afterwards walks correctly.
